uart_tx_formatter: RTL

UART_TX_FORMATTER -- requirements
Module: uart_tx_formatter

---
 rtl/uart_tx_formatter.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_formatter.sv
// uart_tx_formatter: FIFO-buffered unsigned value printer driving a byte UART.
// Define UART_FMT_HEX_EN to add a per-entry hex_mode input (uppercase hex).
module uart_tx_formatter #(
    parameter int DATA_W     = 8,
    parameter int DIGITS     = 3,
    parameter int FIFO_DEPTH = 4,
    parameter int GAP_CYCLES = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_eol,
`ifdef UART_FMT_HEX_EN
    input  logic              hex_mode,
`endif
    output logic              in_ready,
    input  logic              UART_busy,
    output logic [7:0]        data_UART,
    output logic              UART_Enable,
    output logic              idle
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = 4 * DIGITS;
    localparam int HX = (DATA_W + 3) / 4;
    localparam int NP = (DIGITS > HX) ? DIGITS : HX;
    localparam int PW = (NP > 1) ? $clog2(NP) : 1;
    localparam int CW = $clog2(DATA_W + 1);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;

    typedef enum logic [2:0] {IDLE, LOAD, CONV, SEND, GAP} state_t;

    state_t            state;
    logic [DATA_W-1:0] mem_data [FIFO_DEPTH];
    logic              mem_eol  [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [AW:0]       count, count_nx;
    logic              full_q, push, pop, empty;

    logic              e_eol;
    logic [DATA_W-1:0] bin, bin_nx;
    logic [BW-1:0]     bcd, adj, bcd_nx;
    logic [CW-1:0]     conv_cnt;
    logic [PW-1:0]     pos, lead_nx;
    logic [1:0]        tstep;
    logic              last_q;
    logic [GW-1:0]     gap_cnt;
    logic [3:0]        dig;
    logic [7:0]        cur_char;

`ifdef UART_FMT_HEX_EN
    localparam int HXW = 4 * HX;
    logic              mem_hex [FIFO_DEPTH];
    logic              e_hex;
    logic [HXW-1:0]    hexv;
    assign hexv = HXW'(bin);
`endif

    assign empty    = (count == '0);
    assign push     = in_valid & ~full_q;
    assign pop      = (state == IDLE) & ~empty;
    assign in_ready = ~full_q;
    assign idle     = (state == IDLE) & empty;

    // FIFO storage; occupancy gates every read so no reset is needed
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= in_data;
            mem_eol[wr_ptr]  <= in_eol;
`ifdef UART_FMT_HEX_EN
            mem_hex[wr_ptr]  <= hex_mode;
`endif
        end
    end

    // Next occupancy from simultaneous push/pop
    always_comb begin
        count_nx = count;
        if (push & ~pop)
            count_nx = count + (AW+1)'(1);
        else if (~push & pop)
            count_nx = count - (AW+1)'(1);
    end

    // FIFO pointers, occupancy and the registered full flag behind in_ready
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full_q <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count  <= count_nx;
            full_q <= (count_nx == (AW+1)'(FIFO_DEPTH));
        end
    end

    // One double-dabble step and the top nonzero digit of its result
    always_comb begin
        adj = bcd;
        for (int i = 0; i < DIGITS; i++)
            if (bcd[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        bcd_nx  = BW'({adj, bin[DATA_W-1]});
        bin_nx  = {bin[DATA_W-2:0], 1'b0};
        lead_nx = '0;
        for (int i = 0; i < DIGITS; i++)
            if (bcd_nx[4*i +: 4] != 4'd0)
                lead_nx = PW'(i);
    end

    // ASCII for the character selected by pos/tstep
    always_comb begin
        dig = '0;
        for (int i = 0; i < DIGITS; i++)
            if (pos == PW'(i))
                dig = bcd[4*i +: 4];
`ifdef UART_FMT_HEX_EN
        if (e_hex) begin
            dig = '0;
            for (int i = 0; i < HX; i++)
                if (pos == PW'(i))
                    dig = hexv[4*i +: 4];
        end
        cur_char = (dig > 4'd9) ? 8'h37 + {4'h0, dig}
                                : 8'h30 + {4'h0, dig};
`else
        cur_char = 8'h30 + {4'h0, dig};
`endif
        unique case (1'b1)
            (tstep == 2'd1): cur_char = e_eol ? 8'h0D : 8'h20;
            (tstep == 2'd2): cur_char = 8'h0A;
            default: ;
        endcase
    end

    // Formatter FSM: pop, convert, then pace characters out to the UART
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            e_eol       <= 1'b0;
            bin         <= '0;
            bcd         <= '0;
            conv_cnt    <= '0;
            pos         <= '0;
            tstep       <= '0;
            last_q      <= 1'b0;
            gap_cnt     <= '0;
            data_UART   <= 8'h00;
            UART_Enable <= 1'b0;
`ifdef UART_FMT_HEX_EN
            e_hex       <= 1'b0;
`endif
        end else begin
            UART_Enable <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (pop) begin
                        bin   <= mem_data[rd_ptr];
                        e_eol <= mem_eol[rd_ptr];
`ifdef UART_FMT_HEX_EN
                        e_hex <= mem_hex[rd_ptr];
`endif
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    bcd      <= '0;
                    conv_cnt <= '0;
                    tstep    <= 2'd0;
`ifdef UART_FMT_HEX_EN
                    if (e_hex) begin
                        pos   <= PW'(HX - 1);
                        state <= SEND;
                    end else begin
                        state <= CONV;
                    end
`else
                    state    <= CONV;
`endif
                end
                CONV: begin
                    bcd      <= bcd_nx;
                    bin      <= bin_nx;
                    conv_cnt <= conv_cnt + CW'(1);
                    if (conv_cnt == CW'(DATA_W - 1)) begin
                        pos   <= lead_nx;
                        state <= SEND;
                    end
                end
                SEND: begin
                    if (!UART_busy) begin
                        data_UART   <= cur_char;
                        UART_Enable <= 1'b1;
                        gap_cnt     <= '0;
                        state       <= GAP;
                        unique case (1'b1)
                            (tstep == 2'd0): begin
                                last_q <= 1'b0;
                                if (pos == '0)
                                    tstep <= 2'd1;
                                else
                                    pos <= pos - PW'(1);
                            end
                            (tstep == 2'd1): begin
                                last_q <= ~e_eol;
                                tstep  <= 2'd2;
                            end
                            default: last_q <= 1'b1;
                        endcase
                    end
                end
                GAP: begin
                    if (!UART_busy) begin
                        if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
                            gap_cnt <= '0;
                            state   <= last_q ? IDLE : SEND;
                        end else begin
                            gap_cnt <= gap_cnt + GW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
